// File: rtl/jtcop_bac06_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : jtcop_bac06_pkg                                                 |
// | Purpose  : Shared types and helpers for the BAC06 per-line tile fetcher:   |
// |            FSM state encoding, tile/line geometry, buffer-x mapping.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package jtcop_bac06_pkg;

  localparam int c_TILE_W = 8;    // pixels per tile row
  localparam int c_LINE_W = 256;  // visible pixels per line

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAP  = 3'd1,
    ST_MAPW = 3'd2,
    ST_ROM0 = 3'd3,
    ST_ROM1 = 3'd4,
    ST_DRAW = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  // Screen x is a 10-bit two's complement value; only 0..255 lands in the buffer.
  function automatic logic x_visible(input logic [9:0] x);
    return x[9:8] == 2'b00;
  endfunction

  // Buffer address for screen x, mirrored when the screen is flipped.
  function automatic logic [8:0] buf_x(input logic [9:0] x, input logic flip);
    logic [7:0] mirrored;
    mirrored = 8'(c_LINE_W - 1) - x[7:0];
    return {1'b0, flip ? mirrored : x[7:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtcop_bac06_draw.sv
// +----------------------------------------------------------------------------+
// | Module   : jtcop_bac06_draw                                                |
// | Purpose  : Emits the 8 pixels of one fetched tile row, one per clock,      |
// |            computing screen x, horizontal clipping and flip mirroring.     |
// | Ports    : load/pix_in/pal/tile/fx/flip start a tile; abort kills it;      |
// |            buf_addr/buf_data/buf_we drive the line buffer; last flags the  |
// |            cycle carrying the eighth pixel.                                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtcop_bac06_draw
  import jtcop_bac06_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        abort,
  input  logic [31:0] pix_in,
  input  logic [3:0]  pal,
  input  logic [5:0]  tile,
  input  logic [2:0]  fx,
  input  logic        flip,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_data,
  output logic        buf_we,
  output logic        last
);

  logic [27:0] r_sh;      // pixels still to be emitted, leftmost in [27:24]
  logic [2:0]  r_cnt;     // index of the pixel currently on the outputs
  logic        r_active;
  logic [9:0]  r_x;
  logic [3:0]  r_pal;
  logic        r_flip;

  logic [9:0]  w_x0;
  logic [9:0]  w_xn;

  // Leftmost pixel x = tile*8 - fine scroll; goes negative for tile 0.
  assign w_x0 = {1'b0, tile, 3'b000} - {7'd0, fx};
  assign w_xn = r_x + 10'd1;
  assign last = r_active && (r_cnt == 3'(c_TILE_W - 1));

  // The first pixel is presented on the same edge that loads the tile so the
  // whole row occupies exactly the 8 cycles the fetcher spends in DRAW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_x      <= '0;
      r_pal    <= '0;
      r_flip   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
      buf_we   <= 1'b0;
    end else if (abort) begin
      r_active <= 1'b0;
      buf_we   <= 1'b0;
    end else if (load) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_x      <= w_x0;
      r_sh     <= pix_in[27:0];
      r_pal    <= pal;
      r_flip   <= flip;
      buf_we   <= x_visible(w_x0);
      buf_addr <= buf_x(w_x0, flip);
      buf_data <= {pal, pix_in[31:28]};
    end else if (r_active) begin
      if (last) begin
        r_active <= 1'b0;
        buf_we   <= 1'b0;
      end else begin
        r_cnt    <= r_cnt + 3'd1;
        r_x      <= w_xn;
        r_sh     <= {r_sh[23:0], 4'h0};
        buf_we   <= x_visible(w_xn);
        buf_addr <= buf_x(w_xn, r_flip);
        buf_data <= {r_pal, r_sh[27:24]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtcop_bac06_fetch.sv
// +----------------------------------------------------------------------------+
// | Module   : jtcop_bac06_fetch                                               |
// | Purpose  : Per-scanline tile fetch sequencer for one BAC06 tilemap layer.  |
// |            Walks a map RAM row, fetches 4bpp tile rows from ROM and writes |
// |            256 palette-tagged pixels into a line buffer.                   |
// | Ports    : line_st/vrender/scrx/scry/flip/bank - line request and setup    |
// |            ram_addr/ram_dout                   - map RAM (1 clk latency)   |
// |            rom_cs/rom_addr/rom_data/rom_ok     - ROM slot handshake        |
// |            buf_addr/buf_data/buf_we            - line buffer write port    |
// |            busy/done                           - line status               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module jtcop_bac06_fetch
  import jtcop_bac06_pkg::*;
#(
  parameter int MAP_AW = 10,
  parameter int NTILES = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_st,
  input  logic [8:0]        vrender,
  input  logic [9:0]        scrx,
  input  logic [9:0]        scry,
  input  logic              flip,
  input  logic              bank,
  output logic [MAP_AW-1:0] ram_addr,
  input  logic [15:0]       ram_dout,
  output logic              rom_cs,
  output logic [16:0]       rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              rom_ok,
  output logic [8:0]        buf_addr,
  output logic [7:0]        buf_data,
  output logic              buf_we,
  output logic              busy,
  output logic              done
);

  localparam int c_HW = MAP_AW / 2;

  state_t          r_st;
  logic [5:0]      r_t;        // tile counter, 0..NTILES-1
  logic [c_HW-1:0] r_maprow;
  logic [c_HW-1:0] r_x0;
  logic [2:0]      r_fy;
  logic [2:0]      r_fx;
  logic            r_skip;     // first cycle after rom_addr changed: rom_ok is stale
  logic [15:0]     r_w0;       // left half of the tile row
  logic [3:0]      r_pal;

  logic [7:0]      w_yrow;
  logic            w_load;
  logic            w_last;
  logic            w_final;
  logic [c_HW-1:0] w_col_next;
  logic            w_unused;

  assign w_yrow     = vrender[7:0] + scry[7:0];
  assign w_load     = (r_st == ST_ROM1) && !r_skip && rom_ok && !line_st;
  assign w_final    = (r_t == 6'(NTILES - 1));
  assign w_col_next = r_x0 + c_HW'(r_t + 6'd1);
  assign w_unused   = ^{vrender[8], scrx[9:8], scry[9:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= ST_IDLE;
      r_t      <= '0;
      r_maprow <= '0;
      r_x0     <= '0;
      r_fy     <= '0;
      r_fx     <= '0;
      r_skip   <= 1'b0;
      r_w0     <= '0;
      r_pal    <= '0;
      ram_addr <= '0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (line_st) begin
      // A new line always wins, including over a line still in flight.
      r_maprow <= c_HW'(w_yrow[7:3]);
      r_fy     <= w_yrow[2:0];
      r_x0     <= c_HW'(scrx[7:3]);
      r_fx     <= scrx[2:0];
      r_t      <= '0;
      r_skip   <= 1'b0;
      ram_addr <= {c_HW'(w_yrow[7:3]), c_HW'(scrx[7:3])};
      rom_cs   <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
      r_st     <= ST_MAP;
    end else begin
      case (r_st)
        ST_IDLE: ;
        ST_MAP:  r_st <= ST_MAPW;
        ST_MAPW: begin
          r_pal    <= ram_dout[15:12];
          rom_addr <= {bank, ram_dout[11:0], r_fy, 1'b0};
          rom_cs   <= 1'b1;
          r_skip   <= 1'b1;
          r_st     <= ST_ROM0;
        end
        ST_ROM0: begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (rom_ok) begin
            r_w0        <= rom_data;
            rom_addr[0] <= 1'b1;
            r_skip      <= 1'b1;
            r_st        <= ST_ROM1;
          end
        end
        ST_ROM1: begin
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (rom_ok) begin
            rom_cs <= 1'b0;
            r_st   <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (w_last) begin
            if (w_final) begin
              busy <= 1'b0;
              done <= 1'b1;
              r_st <= ST_FIN;
            end else begin
              r_t      <= r_t + 6'd1;
              ram_addr <= {r_maprow, w_col_next};
              r_st     <= ST_MAP;
            end
          end
        end
        ST_FIN: begin
          done <= 1'b0;
          r_st <= ST_IDLE;
        end
        default: r_st <= ST_IDLE;
      endcase
    end
  end

  jtcop_bac06_draw u_draw (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .abort    (line_st),
    .pix_in   ({r_w0, rom_data}),
    .pal      (r_pal),
    .tile     (r_t),
    .fx       (r_fx),
    .flip     (flip),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .buf_we   (buf_we),
    .last     (w_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_jtcop_bac06_fetch.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_jtcop_bac06_fetch                                            |
// | Purpose  : Directed self-checking bench for jtcop_bac06_fetch with map     |
// |            RAM, ROM slot and line buffer models.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_jtcop_bac06_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_st = 1'b0;
  logic [8:0]  vrender = '0;
  logic [9:0]  scrx = '0;
  logic [9:0]  scry = '0;
  logic        flip = 1'b0;
  logic        bank = 1'b0;
  logic [9:0]  ram_addr;
  logic [15:0] ram_dout = '0;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic        rom_ok = 1'b0;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_data;
  logic        buf_we;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  jtcop_bac06_fetch #(.MAP_AW(10), .NTILES(33)) dut (
    .clk(clk), .rst(rst), .line_st(line_st), .vrender(vrender), .scrx(scrx), .scry(scry),
    .flip(flip), .bank(bank), .ram_addr(ram_addr), .ram_dout(ram_dout), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok), .buf_addr(buf_addr),
    .buf_data(buf_data), .buf_we(buf_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Map RAM: word = {addr[3:0], 2'b00, addr}, word 0 overridden to 16'h5123.
  logic [15:0] mem [0:1023];
  always @(posedge clk) ram_dout <= mem[ram_addr];

  // ROM slot: every tile row reads 16'h1234 / 16'h5678. rom_ok rises rom_lat
  // cycles after rom_addr changes; in stale mode rom_ok is also high (with junk
  // data) in the very first cycle after the change.
  int          rom_lat   = 1;
  bit          rom_stale = 1'b0;
  logic [16:0] rom_prev  = '0;
  int          rom_cnt   = 0;
  always @(negedge clk) begin
    if (rom_addr !== rom_prev) begin
      rom_cnt  = 0;
      rom_prev = rom_addr;
    end else begin
      rom_cnt++;
    end
    if (!rom_cs) begin
      rom_ok = 1'b0; rom_data = 16'hDEAD;
    end else if (rom_cnt == 0) begin
      rom_ok = rom_stale; rom_data = 16'hDEAD;
    end else if (rom_cnt >= rom_lat) begin
      rom_ok = 1'b1; rom_data = rom_addr[0] ? 16'h5678 : 16'h1234;
    end else begin
      rom_ok = 1'b0; rom_data = 16'hDEAD;
    end
  end

  // Line buffer and activity recorder.
  logic [7:0]  lbuf     [0:255];
  logic [9:0]  ram_log  [0:63];
  logic [16:0] rom0_log [0:63];
  logic [16:0] rom1_log [0:63];
  int nwr = 0, ndone = 0, nbusy = 0, ntl = 0, nchg = 0;
  logic        prev_cs = 1'b0, prev_half = 1'b0;
  logic [16:0] prev_ra = '0;
  always @(negedge clk) begin
    if (buf_we) begin lbuf[buf_addr[7:0]] = buf_data; nwr++; end
    if (done) ndone++;
    if (busy) nbusy++;
    if (rom_cs && prev_cs && rom_addr !== prev_ra) nchg++;
    if (rom_cs && !prev_cs && ntl < 64) begin
      ram_log[ntl]  = ram_addr;
      rom0_log[ntl] = rom_addr;
    end
    if (rom_cs && rom_addr[0] && !prev_half && ntl < 64) begin
      rom1_log[ntl] = rom_addr;
      ntl++;
    end
    prev_cs   = rom_cs;
    prev_half = rom_cs && rom_addr[0];
    prev_ra   = rom_addr;
  end

  task automatic clear_rec();
    nwr = 0; nbusy = 0; ntl = 0; nchg = 0;
    for (int i = 0; i < 256; i++) lbuf[i] = 8'h00;
  endtask

  task automatic start_line();
    @(negedge clk);
    line_st = 1'b1;
    clear_rec();
    @(negedge clk);
    line_st = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [52:0] v;
    @(negedge clk);
    v = {busy, done, rom_cs, buf_we, ram_addr, rom_addr, buf_addr, buf_data};
    total++;
    if (v !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", v); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_idle busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    bit ok;
    scrx = 0; scry = 0; vrender = 0; flip = 0; bank = 0; ndone = 0;
    start_line();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout got=no_done exp=done"); end
    settle();
    total++;
    if (nbusy !== 462) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=462", nbusy); end
    total++;
    if (ntl !== 33) begin bad++; $display("FAIL basic_tiles got=%0d exp=33", ntl); end
    total++;
    if (ram_log[0] !== 10'd0 || ram_log[1] !== 10'd1 || ram_log[32] !== 10'd0) begin
      bad++; $display("FAIL basic_ram_addr got=%0d,%0d,%0d exp=0,1,0", ram_log[0], ram_log[1], ram_log[32]);
    end
    total++;
    if (rom0_log[0] !== 17'h01230 || rom1_log[0] !== 17'h01231 || rom0_log[1] !== 17'h00010) begin
      bad++; $display("FAIL basic_rom_addr got=%h,%h,%h exp=01230,01231,00010", rom0_log[0], rom1_log[0], rom0_log[1]);
    end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'h51 + 8'(i);
      total++;
      if (lbuf[i] !== e) begin bad++; $display("FAIL basic_pix%0d got=%h exp=%h", i, lbuf[i], e); end
    end
    total++;
    if (lbuf[8] !== 8'h11 || lbuf[255] !== 8'hF8) begin
      bad++; $display("FAIL basic_pix_edges got=%h,%h exp=11,f8", lbuf[8], lbuf[255]);
    end
    total++;
    if (nwr !== 256) begin bad++; $display("FAIL basic_writes got=%0d exp=256", nwr); end
    total++;
    if (ndone !== 1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done got=%0d busy=%b exp=1 busy=0", ndone, busy); end
  endtask

  task automatic test_scroll_x();
    bit ok;
    scrx = 10'd5;
    start_line();
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL scrx_timeout got=no_done exp=done"); end
    settle();
    total++;
    if (lbuf[0] !== 8'h56 || lbuf[2] !== 8'h58 || lbuf[3] !== 8'h11) begin
      bad++; $display("FAIL scrx_left got=%h,%h,%h exp=56,58,11", lbuf[0], lbuf[2], lbuf[3]);
    end
    total++;
    if (lbuf[250] !== 8'hF8 || lbuf[251] !== 8'h51 || lbuf[255] !== 8'h55) begin
      bad++; $display("FAIL scrx_right got=%h,%h,%h exp=f8,51,55", lbuf[250], lbuf[251], lbuf[255]);
    end
    total++;
    if (nwr !== 256) begin bad++; $display("FAIL scrx_writes got=%0d exp=256", nwr); end
  endtask

  task automatic test_wrap();
    bit ok;
    scrx = 10'h0F8; scry = 10'h0FC; vrender = 9'd8; bank = 1'b1;
    start_line();
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    settle();
    total++;
    if (ram_log[0] !== 10'd31 || ram_log[1] !== 10'd0 || ram_log[2] !== 10'd1) begin
      bad++; $display("FAIL wrap_ram_addr got=%0d,%0d,%0d exp=31,0,1", ram_log[0], ram_log[1], ram_log[2]);
    end
    total++;
    if (rom0_log[0] !== 17'h101F8 || rom1_log[1] !== 17'h11239) begin
      bad++; $display("FAIL wrap_rom_addr got=%h,%h exp=101f8,11239", rom0_log[0], rom1_log[1]);
    end
    total++;
    if (lbuf[0] !== 8'hF1 || lbuf[8] !== 8'h51) begin
      bad++; $display("FAIL wrap_pix got=%h,%h exp=f1,51", lbuf[0], lbuf[8]);
    end
    scrx = 0; scry = 0; vrender = 0; bank = 0;
  endtask

  task automatic test_rom_stall();
    bit ok;
    rom_stale = 1'b1; rom_lat = 7;
    start_line();
    wait_done(3000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout got=no_done exp=done"); end
    settle();
    total++;
    if (nbusy !== 858) begin bad++; $display("FAIL stall_busy_cycles got=%0d exp=858", nbusy); end
    total++;
    if (lbuf[0] !== 8'h51 || lbuf[7] !== 8'h58 || lbuf[255] !== 8'hF8) begin
      bad++; $display("FAIL stall_pix got=%h,%h,%h exp=51,58,f8", lbuf[0], lbuf[7], lbuf[255]);
    end
    total++;
    if (nchg !== 33) begin bad++; $display("FAIL stall_addr_changes got=%0d exp=33", nchg); end
    total++;
    if (nwr !== 256) begin bad++; $display("FAIL stall_writes got=%0d exp=256", nwr); end
    rom_stale = 1'b0; rom_lat = 1;
  endtask

  task automatic test_restart();
    bit ok;
    bit hit;
    ndone = 0;
    start_line();
    hit = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (nwr >= 99) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL restart_reach_tile12 got=%0d exp>=99", nwr); end
    line_st = 1'b1; scrx = 10'd8;
    @(negedge clk);
    line_st = 1'b0;
    total++;
    if (buf_we !== 1'b0 || rom_cs !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart_abort we=%b cs=%b busy=%b exp=0,0,1", buf_we, rom_cs, busy);
    end
    clear_rec();
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL restart_no_done got=%0d exp=0", ndone); end
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL restart_timeout got=no_done exp=done"); end
    repeat (40) @(negedge clk);
    total++;
    if (ndone !== 1 || nwr !== 256 || ntl !== 33) begin
      bad++; $display("FAIL restart_line got=done%0d wr%0d tl%0d exp=1,256,33", ndone, nwr, ntl);
    end
    total++;
    if (ram_log[0] !== 10'd1 || lbuf[0] !== 8'h11 || lbuf[255] !== 8'h58) begin
      bad++; $display("FAIL restart_relatch got=%0d,%h,%h exp=1,11,58", ram_log[0], lbuf[0], lbuf[255]);
    end
    scrx = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    ndone = 0;
    start_line();
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_first_timeout got=no_done exp=done"); end
    line_st = 1'b1;
    clear_rec();
    @(negedge clk);
    line_st = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL b2b_second_timeout got=no_done exp=done"); end
    settle();
    total++;
    if (ndone !== 2 || nwr !== 256) begin
      bad++; $display("FAIL b2b_counts got=done%0d wr%0d exp=2,256", ndone, nwr);
    end
  endtask

  task automatic test_flip_and_rst();
    bit ok;
    bit hit;
    logic [52:0] v;
    flip = 1'b1;
    start_line();
    wait_done(2000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL flip_timeout got=no_done exp=done"); end
    settle();
    total++;
    if (lbuf[255] !== 8'h51 || lbuf[248] !== 8'h58 || lbuf[0] !== 8'hF8) begin
      bad++; $display("FAIL flip_pix got=%h,%h,%h exp=51,58,f8", lbuf[255], lbuf[248], lbuf[0]);
    end
    ndone = 0;
    start_line();
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (nwr >= 20) begin hit = 1'b1; break; end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rst_reach_draw got=%0d exp>=20", nwr); end
    #2 rst = 1'b1;
    #1;
    v = {busy, done, rom_cs, buf_we, ram_addr, rom_addr, buf_addr, buf_data};
    total++;
    if (v !== '0) begin bad++; $display("FAIL rst_async got=%h exp=0", v); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    total++;
    if (ndone !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_done got=done%0d busy=%b exp=0,0", ndone, busy);
    end
    flip = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {i[3:0], 2'b00, i[9:0]};
    mem[0] = 16'h5123;
    test_reset();
    test_basic();
    test_scroll_x();
    test_wrap();
    test_rom_stall();
    test_restart();
    test_back_to_back();
    test_flip_and_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
